// File: rtl/simd_rf_pkg.sv
// simd_regfile_sb shared definitions: PPP lane encodings,
// clear-sequencer states and the PPP legality helper.
package simd_rf_pkg;

  localparam logic [2:0] PPP_ALL   = 3'b000;
  localparam logic [2:0] PPP_UPPER = 3'b001;
  localparam logic [2:0] PPP_LOWER = 3'b010;
  localparam logic [2:0] PPP_EVEN  = 3'b011;
  localparam logic [2:0] PPP_ODD   = 3'b100;

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } st_t;

  function automatic logic ppp_legal(input logic [2:0] ppp);
    return ppp <= PPP_ODD;
  endfunction

endpackage

// File: rtl/simd_rf_if.sv
// Issue/writeback/clear bundle of the SIMD register file.
// master drives requests, slave is the register file.
interface simd_rf_if #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 32,
  parameter int NRD    = 2
) ();
  localparam int ADDR_W = $clog2(DEPTH);

  logic [NRD*ADDR_W-1:0] rd_addr;
  logic [NRD*DATA_W-1:0] rd_data;
  logic [NRD-1:0]        rd_busy;
  logic                  wr_en;
  logic [ADDR_W-1:0]     wr_addr;
  logic [DATA_W-1:0]     wr_data;
  logic [2:0]            wr_ppp;
  logic                  wr_ready;
  logic                  sb_set_en;
  logic [ADDR_W-1:0]     sb_set_addr;
  logic                  clr_req;
  logic                  clr_busy;
  logic                  illegal_ppp;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, wr_ppp,
    output sb_set_en, sb_set_addr, clr_req,
    input  rd_data, rd_busy, wr_ready, clr_busy,
    input  illegal_ppp
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, wr_ppp,
    input  sb_set_en, sb_set_addr, clr_req,
    output rd_data, rd_busy, wr_ready, clr_busy,
    output illegal_ppp
  );
endinterface

// File: rtl/simd_ppp_mask.sv
// PPP field to byte-lane mask; mask bit b covers bits [8b+7:8b].
// Byte numbering for PPP purposes runs from the MSB byte.
module simd_ppp_mask
  import simd_rf_pkg::*;
#(
  parameter int DATA_W = 64,
  localparam int NB    = DATA_W / 8
) (
  input  logic [2:0]    i_ppp,
  output logic [NB-1:0] o_mask,
  output logic          o_legal
);

  always_comb begin
    o_mask  = '0;
    o_legal = ppp_legal(i_ppp);
    for (int b = 0; b < NB; b++) begin
      // MSB-relative index NB-1-b is even exactly when b is odd
      unique case (1'b1)
        (i_ppp == PPP_ALL):   o_mask[b] = 1'b1;
        (i_ppp == PPP_UPPER): o_mask[b] = (b >= NB / 2);
        (i_ppp == PPP_LOWER): o_mask[b] = (b < NB / 2);
        (i_ppp == PPP_EVEN):  o_mask[b] = ((b % 2) == 1);
        (i_ppp == PPP_ODD):   o_mask[b] = ((b % 2) == 0);
        default:              o_mask[b] = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/simd_regfile_sb.sv
// SIMD register file: multi-port reads with lane-masked forwarding,
// PPP partial writes, pending scoreboard and a sequential clear.
module simd_regfile_sb
  import simd_rf_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int NRD    = 2
) (
  input logic     clk,
  input logic     reset,
  simd_rf_if.slave bus
);

  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  r_pend;
  st_t               r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_ill;

  st_t               w_state_nxt;
  logic [ADDR_W-1:0] w_cnt_nxt;
  logic [DEPTH-1:0]  w_pend_nxt;
  logic [NB-1:0]     w_mask;
  logic              w_legal;
  logic [DATA_W-1:0] w_bm;
  logic              w_ready;
  logic              w_wr_ok;
  logic              w_ill;
  logic [NRD*DATA_W-1:0] w_rd_data;
  logic [NRD-1:0]        w_rd_busy;

  simd_ppp_mask #(.DATA_W(DATA_W)) u_mask (
    .i_ppp   (bus.wr_ppp),
    .o_mask  (w_mask),
    .o_legal (w_legal)
  );

  always_comb begin
    w_bm = '0;
    for (int b = 0; b < NB; b++) begin
      w_bm[b*8 +: 8] = {8{w_mask[b]}};
    end
  end

  assign w_ready = (r_state == ST_IDLE);
  assign w_ill   = bus.wr_en & w_ready & ~w_legal;
  assign w_wr_ok = bus.wr_en & w_ready & w_legal
                 & (bus.wr_addr != '0);

  always_comb begin
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic              f;
    a = '0;
    d = '0;
    f = 1'b0;
    w_rd_data = '0;
    w_rd_busy = '0;
    for (int k = 0; k < NRD; k++) begin
      a = bus.rd_addr[k*ADDR_W +: ADDR_W];
      f = w_wr_ok && (bus.wr_addr == a);
      d = r_mem[a];
      if (f) d = (d & ~w_bm) | (bus.wr_data & w_bm);
      if (a == '0) d = '0;
      w_rd_data[k*DATA_W +: DATA_W] = d;
      w_rd_busy[k] = r_pend[a] & ~f;
    end
  end

  // clear is applied last so it beats a same-cycle issue set
  always_comb begin
    w_pend_nxt = r_pend;
    if (w_wr_ok) w_pend_nxt[bus.wr_addr] = 1'b0;
    if (bus.sb_set_en) w_pend_nxt[bus.sb_set_addr] = 1'b1;
    if (r_state == ST_CLEAR) w_pend_nxt[r_cnt] = 1'b0;
    w_pend_nxt[0] = 1'b0;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.clr_req) begin
          w_state_nxt = ST_CLEAR;
          w_cnt_nxt   = '0;
        end
      end
      ST_CLEAR: begin
        w_cnt_nxt = r_cnt + ADDR_W'(1);
        if (r_cnt == ADDR_W'(DEPTH - 1)) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_pend  <= '0;
      r_ill   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pend  <= w_pend_nxt;
      r_ill   <= w_ill;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (r_state == ST_CLEAR) begin
      r_mem[r_cnt] <= '0;
    end else if (w_wr_ok) begin
      r_mem[bus.wr_addr] <= (r_mem[bus.wr_addr] & ~w_bm)
                          | (bus.wr_data & w_bm);
    end
  end

  assign bus.rd_data     = w_rd_data;
  assign bus.rd_busy     = w_rd_busy;
  assign bus.wr_ready    = w_ready;
  assign bus.clr_busy    = (r_state == ST_CLEAR);
  assign bus.illegal_ppp = r_ill;

endmodule

// File: tb/tb_simd_regfile_sb.sv
// Directed bench for simd_regfile_sb (64-bit, 32 regs, 2 ports).
// Inputs change 1ns after posedge; outputs checked before next edge.
module tb_simd_regfile_sb;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  simd_rf_if #(.DATA_W(64), .DEPTH(32), .NRD(2)) bus ();

  simd_regfile_sb #(
    .DATA_W (64),
    .DEPTH  (32),
    .ADDR_W (5),
    .NRD    (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    bus.rd_addr = {a1, a0};
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [63:0] d,
                    input logic [2:0] p);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    bus.wr_ppp  = p;
    #1;
  endtask

  task automatic idle();
    bus.wr_en     = 1'b0;
    bus.sb_set_en = 1'b0;
    bus.clr_req   = 1'b0;
    #1;
  endtask

  function automatic logic [63:0] p0();
    return bus.rd_data[63:0];
  endfunction

  function automatic logic [63:0] p1();
    return bus.rd_data[127:64];
  endfunction

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    bus.rd_addr     = '0;
    bus.wr_en       = 1'b0;
    bus.wr_addr     = '0;
    bus.wr_data     = '0;
    bus.wr_ppp      = '0;
    bus.sb_set_en   = 1'b0;
    bus.sb_set_addr = '0;
    bus.clr_req     = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    rd(5'd5, 5'd9);
    chk("rst_clr_busy", 64'(bus.clr_busy), 64'd0);
    chk("rst_wr_ready", 64'(bus.wr_ready), 64'd1);
    chk("rst_rd0", p0(), 64'd0);
    chk("rst_busy", 64'(bus.rd_busy), 64'd0);
    chk("rst_ill", 64'(bus.illegal_ppp), 64'd0);

    wr(5'd5, 64'h0123_4567_89AB_CDEF, 3'b000);
    tick();
    wr(5'd5, 64'hFFFF_FFFF_FFFF_FFFF, 3'b010);
    chk("r5_fwd_lower", p0(), 64'h0123_4567_FFFF_FFFF);
    tick();
    idle();
    chk("r5_lower", p0(), 64'h0123_4567_FFFF_FFFF);

    rd(5'd7, 5'd7);
    wr(5'd7, 64'hFFFF_FFFF_FFFF_FFFF, 3'b011);
    chk("r7_fwd_p0", p0(), 64'hFF00_FF00_FF00_FF00);
    chk("r7_fwd_p1", p1(), 64'hFF00_FF00_FF00_FF00);
    tick();
    idle();
    chk("r7_even", p1(), 64'hFF00_FF00_FF00_FF00);
    wr(5'd7, 64'h1111_2222_3333_4444, 3'b100);
    tick();
    idle();
    chk("r7_odd", p0(), 64'hFF11_FF22_FF33_FF44);
    wr(5'd7, 64'hAAAA_BBBB_CCCC_DDDD, 3'b001);
    tick();
    idle();
    chk("r7_upper", p0(), 64'hAAAA_BBBB_FF33_FF44);

    bus.sb_set_en   = 1'b1;
    bus.sb_set_addr = 5'd3;
    tick();
    idle();
    rd(5'd3, 5'd3);
    wr(5'd3, 64'h5555_5555_5555_5555, 3'b110);
    chk("ill_nofwd", p0(), 64'd0);
    chk("ill_busy_in", 64'(bus.rd_busy), 64'b11);
    chk("ill_no_pulse_yet", 64'(bus.illegal_ppp), 64'd0);
    tick();
    idle();
    chk("ill_pulse", 64'(bus.illegal_ppp), 64'd1);
    chk("ill_r3", p0(), 64'd0);
    chk("ill_busy_kept", 64'(bus.rd_busy), 64'b11);
    tick();
    chk("ill_pulse_end", 64'(bus.illegal_ppp), 64'd0);

    rd(5'd9, 5'd5);
    bus.sb_set_en   = 1'b1;
    bus.sb_set_addr = 5'd9;
    tick();
    idle();
    chk("r9_busy", 64'(bus.rd_busy[0]), 64'd1);
    wr(5'd9, 64'h0000_0000_0000_00AA, 3'b000);
    chk("r9_bypass", 64'(bus.rd_busy[0]), 64'd0);
    tick();
    idle();
    chk("r9_cleared", 64'(bus.rd_busy[0]), 64'd0);
    chk("r9_data", p0(), 64'h0000_0000_0000_00AA);
    bus.sb_set_en   = 1'b1;
    bus.sb_set_addr = 5'd9;
    wr(5'd9, 64'h0000_0000_0000_00BB, 3'b000);
    tick();
    idle();
    chk("r9_set_wins", 64'(bus.rd_busy[0]), 64'd1);

    rd(5'd0, 5'd0);
    bus.sb_set_en   = 1'b1;
    bus.sb_set_addr = 5'd0;
    wr(5'd0, 64'hDEAD_BEEF_DEAD_BEEF, 3'b000);
    chk("r0_fwd", p0(), 64'd0);
    tick();
    idle();
    chk("r0_data", p1(), 64'd0);
    chk("r0_busy", 64'(bus.rd_busy), 64'd0);

    for (int i = 1; i < 32; i++) begin
      wr(5'(i), 64'hA5A5_0000_1234_0000 | 64'(i), 3'b000);
      tick();
    end
    idle();
    bus.sb_set_en   = 1'b1;
    bus.sb_set_addr = 5'd12;
    tick();
    idle();
    rd(5'd31, 5'd12);
    chk("load_r31", p0(), 64'hA5A5_0000_1234_001F);
    chk("r12_busy", 64'(bus.rd_busy[1]), 64'd1);

    bus.clr_req = 1'b1;
    tick();
    rd(5'd4, 5'd31);
    wr(5'd4, 64'hFFFF_FFFF_FFFF_FFFF, 3'b000);
    for (int c = 0; c < 32; c++) begin
      if (c == 2) bus.clr_req = 1'b0;
      if (c == 0) begin
        chk("clr_nofwd", p0(), 64'hA5A5_0000_1234_0004);
        chk("clr_partial", p1(), 64'hA5A5_0000_1234_001F);
      end
      chk($sformatf("clr_busy_%0d", c), 64'(bus.clr_busy), 64'd1);
      chk($sformatf("clr_rdy_%0d", c), 64'(bus.wr_ready), 64'd0);
      if (c == 31) idle();
      tick();
    end
    chk("clr_done", 64'(bus.clr_busy), 64'd0);
    chk("clr_rdy_back", 64'(bus.wr_ready), 64'd1);
    for (int i = 1; i < 32; i++) begin
      rd(5'(i), 5'd12);
      chk($sformatf("clr_r%0d", i), p0(), 64'd0);
    end
    chk("clr_pend", 64'(bus.rd_busy), 64'd0);

    wr(5'd1, 64'h1111_1111_1111_1111, 3'b000);
    tick();
    wr(5'd31, 64'h3131_3131_3131_3131, 3'b000);
    tick();
    idle();
    rd(5'd1, 5'd31);
    chk("reload_r31", p1(), 64'h3131_3131_3131_3131);
    bus.clr_req = 1'b1;
    tick();
    idle();
    for (int c = 0; c < 10; c++) tick();
    chk("abort_busy_pre", 64'(bus.clr_busy), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("abort_busy", 64'(bus.clr_busy), 64'd0);
    chk("abort_rdy", 64'(bus.wr_ready), 64'd1);
    chk("abort_r1", p0(), 64'd0);
    chk("abort_r31", p1(), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/simd_regfile_sb.md
Name: simd_regfile_sb

Overview:
- Parametrised successor to the team's 64-bit SIMD register file.
- Multi-port read, PPP (participation) partial-lane writes, and write-to-read forwarding that honours the lane mask.
- Per-register scoreboard (pending bits) for issue hazard detection.
- Multi-cycle clear sequencer that zeroes the array without a global reset.
- Sits between the decode/issue stage (reads, scoreboard set) and writeback (writes).

Parameters:
- DATA_W, 64, register width in bits; multiple of 16.
- DEPTH, 32, number of registers; power of 2, at least 2.
- ADDR_W, $clog2(DEPTH), register address width.
- NRD, 2, number of read ports.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high; clock clk.
- rd_addr  in  NRD*ADDR_W  read addresses; port k at [k*ADDR_W +: ADDR_W].
- rd_data  out  NRD*DATA_W  read data, port k at [k*DATA_W +: DATA_W].
- rd_busy  out  NRD  pending bit of the addressed register, with writeback bypass.
- wr_en  in  1  writeback request.
- wr_addr  in  ADDR_W  writeback address.
- wr_data  in  DATA_W  writeback data.
- wr_ppp  in  3  participation field.
- wr_ready  out  1  writeback accepted this cycle (low during clear).
- sb_set_en  in  1  issue marks a destination register pending.
- sb_set_addr  in  ADDR_W  destination register to mark.
- clr_req  in  1  start a sequential clear.
- clr_busy  out  1  clear in progress.
- illegal_ppp  out  1  one-cycle pulse, the cycle after an illegal PPP write was presented.

Behaviour:
- Lane mask, with byte 0 as the MSB byte. Bytes are numbered 0..DATA_W/8-1 from the MSB.
  - 000: all bytes.
  - 001: upper half, [DATA_W-1:DATA_W/2].
  - 010: lower half.
  - 011: even-indexed bytes (for 64-bit: [63:56], [47:40], [31:24], [15:8]).
  - 100: odd-indexed bytes.
  - 101-111: illegal.
- A legal write is: wr_en & wr_ready & ppp legal & wr_addr != 0.
- Write: on a legal write, at the clk edge, only masked bytes of regfile[wr_addr] update. All other bytes hold.
- Illegal ppp with wr_en & wr_ready:
  - No array change, no scoreboard change.
  - illegal_ppp=1 for exactly the next cycle.
- Register 0:
  - Always reads zero.
  - Never written, never pending.
  - rd_busy for address 0 is always 0.
- Read (combinational, zero latency), per port and per byte:
  - If a legal write targets the same address and the byte is in the mask, return the wr_data byte.
  - Otherwise return the stored byte.
- Scoreboard pending[DEPTH-1:0]:
  - sb_set_en sets pending[sb_set_addr] at the edge.
  - A legal write clears pending[wr_addr].
  - Set and clear to the same address in the same cycle: set wins.
  - sb_set_addr=0 is ignored.
- rd_busy[k] = pending[rd_addr_k] & ~(legal write to rd_addr_k this cycle).
- Clear FSM, states IDLE and CLEAR:
  - IDLE: clr_req=1 moves to CLEAR next cycle, with counter=0.
  - CLEAR: each cycle writes zero to regfile[counter] and clears pending[counter], then increments counter.
  - CLEAR: when counter==DEPTH-1, returns to IDLE.
  - clr_busy=1 and wr_ready=0 for exactly DEPTH cycles.
  - clr_req during CLEAR is ignored.
  - Writes presented while wr_ready=0 are dropped; upstream holds them. No forwarding and no illegal_ppp pulse for dropped writes.
  - sb_set_en during CLEAR: a set applies, unless the same cycle clears that index (clear wins).
  - Reads during CLEAR return current contents, partially cleared.
- wr_ready = (state==IDLE). It is combinational from state only, not from clr_req.
- Reset:
  - All registers 0, pending 0, state IDLE, counter 0, illegal_ppp 0.
  - Outputs after reset: clr_busy=0, wr_ready=1, rd_data=0, rd_busy=0.
  - Reset mid-clear aborts the clear immediately.
  - Reset dominates all other inputs in the same cycle.
- No simulation-only prints in synthesizable paths.

Decomposition:
- Package simd_rf_pkg holds:
  - PPP encoding localparams (PPP_ALL, PPP_UPPER, PPP_LOWER, PPP_EVEN, PPP_ODD).
  - FSM state typedef (ST_IDLE, ST_CLEAR).
  - Function ppp_legal().
- One sub-module, simd_ppp_mask:
  - Parametrised by DATA_W.
  - Maps wr_ppp to a DATA_W/8-bit byte mask plus a legal flag.
  - Shared by the write path and the forwarding path.

Test Plan:
- Reset, then write r5=64'h0123456789ABCDEF with ppp=000, then write r5=64'hFFFFFFFF_FFFFFFFF with ppp=010 -> r5 reads 64'h01234567_FFFFFFFF.
- r7=0, write r7=64'hFFFF...FF with ppp=011 -> r7 reads 64'hFF00FF00FF00FF00. The same-cycle read on both ports already shows the forwarded value.
- Write r3 with ppp=110 -> r3 unchanged, illegal_ppp pulses for one cycle, pending unchanged.
- Pending set on r9:
  - sb_set_en on r9 -> rd_busy=1 on r9 the next cycle.
  - Write to r9 -> rd_busy=0 in the write cycle (bypass) and after it.
  - Simultaneous sb_set and write to r9 -> stays pending.
- Writes to r0 with any data -> r0 reads 0, rd_busy=0.
- Load r1..r31 with nonzero values, pulse clr_req:
  - clr_busy high for 32 cycles, wr_ready low, writes dropped.
  - Afterwards all registers read 0.
  - A repeat with reset asserted at clear cycle 10 -> IDLE and all zeros the next cycle.
